// File: rtl/sdft_pkg.sv
// Shared FSM encoding and width/iteration-count rules for the complex arithmetic blocks.
// Pure declarations; no latency, no handshake.
package sdft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a sum of two products of in_w-bit signed operands.
  function automatic int prod_w(input int in_w);
    return 2 * in_w + 1;
  endfunction

  function automatic int iter_n(input int in_w, input int fr_w);
    return prod_w(in_w) + fr_w;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_udiv.sv
// Unsigned restoring divider, one quotient bit per clock; the start edge already retires bit one.
// The iteration count is owned by the caller, which raises last on the final step; done pulses after it.
module serial_udiv #(
  parameter int n_w = 25,
  parameter int d_w = 17
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           last,
  input  logic [n_w-1:0] dividend,
  input  logic [d_w-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [n_w-1:0] quotient
);

  logic [d_w:0]   rem;
  logic [d_w:0]   rem_src;
  logic [d_w:0]   shifted;
  logic [d_w:0]   diff;
  logic [n_w-1:0] q_src;
  logic           take;

  // The quotient register doubles as the dividend shifter: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    rem_src = start ? '0 : rem;
    q_src   = start ? dividend : quotient;
    shifted = {rem_src[d_w-1:0], q_src[n_w-1]};
    take    = (shifted >= {1'b0, divisor});
    diff    = shifted - {1'b0, divisor};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem      <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        rem      <= take ? diff : shifted;
        quotient <= {q_src[n_w-2:0], take};
      end
      if (start) begin
        busy <= 1'b1;
      end else if (busy && last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/complex_div.sv
// Fixed-point complex divide q = a*conj(b)*2^frac_w/|b|^2, truncated toward zero and saturated.
// Latency N+2 edges (2 for a zero divisor); one operation in flight, result held until out_ready.
module complex_div
  import sdft_pkg::*;
#(
  parameter int data_in_w  = 8,
  parameter int data_out_w = 16,
  parameter int frac_w     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [data_in_w-1:0]  a_real,
  input  logic signed [data_in_w-1:0]  a_imag,
  input  logic signed [data_in_w-1:0]  b_real,
  input  logic signed [data_in_w-1:0]  b_imag,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [data_out_w-1:0] out_real,
  output logic signed [data_out_w-1:0] out_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         div_zero,
  output logic                         sat
);

  localparam int pw  = prod_w(data_in_w);
  localparam int nit = iter_n(data_in_w, frac_w);
  localparam int cw  = cnt_w(nit);
  localparam logic signed [data_out_w-1:0] omax = {1'b0, {(data_out_w-1){1'b1}}};
  localparam logic signed [data_out_w-1:0] omin = {1'b1, {(data_out_w-1){1'b0}}};

  state_t                       state;
  logic                         ld_ph;
  logic signed [data_in_w-1:0]  ar, ai, br, bi;
  logic signed [pw-1:0]         nr_c, ni_c;
  logic [pw-1:0]                d_c;
  logic                         nr_neg, ni_neg;
  logic [pw-1:0]                nr_mag, ni_mag, den;
  logic [cw-1:0]                cnt;
  logic                         start, last;
  logic                         busy_r, busy_i, done_r, done_i;
  logic [nit-1:0]               q_r, q_i;
  logic signed [data_out_w-1:0] res_r, res_i;
  logic                         sat_r, sat_i;

  assign nr_c = pw'(ar) * pw'(br) + pw'(ai) * pw'(bi);
  assign ni_c = pw'(ai) * pw'(br) - pw'(ar) * pw'(bi);
  assign d_c  = $unsigned(pw'(br) * pw'(br) + pw'(bi) * pw'(bi));

  assign start = (state == LOAD) && ld_ph && (den != '0);
  assign last  = (cnt == cw'(nit - 1));

  // Returns {saturated, value}; the negative bound is one larger in magnitude.
  function automatic logic [data_out_w:0] clamp(input logic neg, input logic [nit-1:0] mag);
    logic [nit-1:0]        lim;
    logic [data_out_w-1:0] m;
    lim = neg ? nit'({1'b1, {(data_out_w-1){1'b0}}}) : nit'({1'b0, {(data_out_w-1){1'b1}}});
    m   = mag[data_out_w-1:0];
    if (mag > lim) return {1'b1, neg ? omin : omax};
    return {1'b0, neg ? -m : m};
  endfunction

  assign {sat_r, res_r} = clamp(nr_neg, q_r);
  assign {sat_i, res_i} = clamp(ni_neg, q_i);

  serial_udiv #(.n_w(nit), .d_w(pw)) u_div_real (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .last     (last),
    .dividend ({nr_mag, {frac_w{1'b0}}}),
    .divisor  (den),
    .busy     (busy_r),
    .done     (done_r),
    .quotient (q_r)
  );

  serial_udiv #(.n_w(nit), .d_w(pw)) u_div_imag (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .last     (last),
    .dividend ({ni_mag, {frac_w{1'b0}}}),
    .divisor  (den),
    .busy     (busy_i),
    .done     (done_i),
    .quotient (q_i)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ld_ph     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      div_zero  <= 1'b0;
      sat       <= 1'b0;
      cnt       <= '0;
      ar        <= '0;
      ai        <= '0;
      br        <= '0;
      bi        <= '0;
      nr_neg    <= 1'b0;
      ni_neg    <= 1'b0;
      nr_mag    <= '0;
      ni_mag    <= '0;
      den       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            ar       <= a_real;
            ai       <= a_imag;
            br       <= b_real;
            bi       <= b_imag;
            in_ready <= 1'b0;
            ld_ph    <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          ld_ph <= 1'b1;
          // First LOAD cycle registers the products; the second dispatches on the divisor.
          if (!ld_ph) begin
            nr_neg <= nr_c[pw-1];
            ni_neg <= ni_c[pw-1];
            nr_mag <= nr_c[pw-1] ? $unsigned(-nr_c) : $unsigned(nr_c);
            ni_mag <= ni_c[pw-1] ? $unsigned(-ni_c) : $unsigned(ni_c);
            den    <= d_c;
          end else if (den == '0) begin
            out_real  <= '0;
            out_imag  <= '0;
            div_zero  <= 1'b1;
            sat       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt   <= cw'(1);
            state <= DIV;
          end
        end
        DIV: begin
          if (busy_r || busy_i) cnt <= cnt + cw'(1);
          if (done_r && done_i) begin
            out_real  <= res_r;
            out_imag  <= res_i;
            sat       <= sat_r || sat_i;
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// Scoreboard bench for complex_div: driver pushes model results, monitor pops on out_valid.
// Covers reset values, directed corner vectors, random traffic, output hold and mid-divide reset.
module tb_complex_div;

  localparam int W  = 8;
  localparam int OW = 16;
  localparam int FR = 8;
  localparam int N  = 2 * W + 1 + FR;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic signed [W-1:0]  a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [OW-1:0] out_real, out_imag;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 div_zero, sat;

  typedef struct {
    int  re;
    int  im;
    bit  dz;
    bit  st;
    int  lat;
    time t_acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   hold_force = 1'b0;

  always #5 clk = ~clk;

  complex_div #(.data_in_w(W), .data_out_w(OW), .frac_w(FR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_real    (a_real),
    .a_imag    (a_imag),
    .b_real    (b_real),
    .b_imag    (b_imag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .div_zero  (div_zero),
    .sat       (sat)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Plain integer arithmetic: SV int division truncates toward zero.
  function automatic exp_t model(input int ar, input int ai, input int br, input int bi);
    exp_t e;
    int nr, ni, d, lo, hi;
    lo = -(1 << (OW - 1));
    hi = (1 << (OW - 1)) - 1;
    nr = ar * br + ai * bi;
    ni = ai * br - ar * bi;
    d  = br * br + bi * bi;
    e.st = 1'b0;
    e.t_acc = 0;
    if (d == 0) begin
      e.re = 0; e.im = 0; e.dz = 1'b1; e.lat = 2;
    end else begin
      e.dz = 1'b0; e.lat = N + 2;
      e.re = (nr * (1 << FR)) / d;
      e.im = (ni * (1 << FR)) / d;
      if (e.re > hi) begin e.re = hi; e.st = 1'b1; end
      if (e.re < lo) begin e.re = lo; e.st = 1'b1; end
      if (e.im > hi) begin e.im = hi; e.st = 1'b1; end
      if (e.im < lo) begin e.im = lo; e.st = 1'b1; end
    end
    return e;
  endfunction

  task automatic send(input int ar, input int ai, input int br, input int bi, input bit track);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, expected 1", in_ready, w);
      return;
    end
    a_real = W'(ar); a_imag = W'(ai); b_real = W'(br); b_imag = W'(bi);
    in_valid = 1'b1;
    @(posedge clk);
    if (track) begin
      e = model(ar, ai, br, bi);
      e.t_acc = $time;
      exp_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    a_real = W'($urandom); a_imag = W'($urandom);
    b_real = W'($urandom); b_imag = W'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  function automatic int rnd_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Monitor: pops on the first cycle of each result, then checks it stays put until taken.
  initial begin
    exp_t           e;
    bit             holding = 1'b0;
    logic [2*OW+1:0] snap = '0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_result: out_valid=1 with got re=%0d im=%0d, expected no result",
                     out_real, out_imag);
          end else begin
            e = exp_q.pop_front();
            chk("out_real", out_real, e.re);
            chk("out_imag", out_imag, e.im);
            chk("div_zero", div_zero, e.dz);
            chk("sat", sat, e.st);
            chk("latency", longint'((($time - 5) - e.t_acc) / 10), e.lat);
          end
          snap = {out_real, out_imag, div_zero, sat};
          holding = 1'b1;
        end else begin
          chk("hold_stable", {out_real, out_imag, div_zero, sat}, snap);
        end
        chk("in_ready_while_valid", in_ready, 0);
        out_ready = hold_force ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (out_ready) holding = 1'b0;
      end else begin
        holding = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int ar, ai, br, bi, w;

    #1 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_imag", out_imag, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_sat", sat, 0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready_held", in_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    send(4, 0, 2, 0, 1);
    send(1, 1, 1, -1, 1);
    send(0, 3, 0, 3, 1);
    send(-1, 0, 3, 0, 1);
    send(-7, 0, 2, 0, 1);
    send(-128, -128, 0, 1, 1);
    send(5, -9, 0, 0, 1);
    send(-128, 127, 0, 0, 1);
    send(127, 127, -128, -128, 1);
    send(-128, -128, -1, 0, 1);
    drain();

    // Result must sit unchanged while the consumer stalls.
    hold_force = 1'b1;
    send(100, -50, 3, 7, 1);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("hold_result_seen", out_valid, 1);
    repeat (10) @(negedge clk);
    hold_force = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      ar = rnd_s8(); ai = rnd_s8();
      if ($urandom_range(0, 7) == 0) begin
        br = 0; bi = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        br = int'($urandom_range(0, 4)) - 2; bi = int'($urandom_range(0, 4)) - 2;
      end else begin
        br = rnd_s8(); bi = rnd_s8();
      end
      send(ar, ai, br, bi, 1);
    end
    drain();

    // Reset partway through a divide: the operation must vanish.
    send(50, 20, 3, 1, 0);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_rst_out_valid", out_valid, 0);
    chk("abort_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_after_release", in_ready, 1);
    repeat (40) @(negedge clk);
    chk("abort_no_result", out_valid, 0);

    for (int i = 0; i < 5; i++) send(rnd_s8(), rnd_s8(), rnd_s8(), rnd_s8(), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/complex_div.md
COMPLEX_DIV -- requirements
Module: complex_div

Interface
REQ-001 Parameter data_in_w, default 8: signed operand width for each component.
REQ-002 Parameter data_out_w, default 16: signed result width for each component.
REQ-003 Parameter frac_w, default 8: fractional bits of the fixed-point result.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Ports a_real, a_imag  input  data_in_w each  signed dividend components.
REQ-007 Ports b_real, b_imag  input  data_in_w each  signed divisor components.
REQ-008 Port in_valid  input  1  operands valid; in_ready  output  1  block can accept.
REQ-009 Ports out_real, out_imag  output  data_out_w each  signed quotient, Q(data_out_w-frac_w).frac_w.
REQ-010 Port out_valid  input/output pair: out_valid output 1, out_ready input 1, result handshake.
REQ-011 Port div_zero  output  1  result came from a zero divisor.
REQ-012 Port sat  output  1  one or both components saturated.

Function
REQ-013 The block SHALL compute q = (a * conj(b)) * 2^frac_w / |b|^2 per component, truncated toward zero.
REQ-014 Numerators: nr = a_r*b_r + a_i*b_i, ni = a_i*b_r - a_r*b_i, each 2*data_in_w+1 bits signed; denominator d = b_r^2 + b_i^2, 2*data_in_w+1 bits unsigned.
REQ-015 Division SHALL run on magnitudes with a restoring, one-bit-per-cycle algorithm; sign reapplied afterward; N = 2*data_in_w+1+frac_w iterations (25 at defaults).
REQ-016 FSM states: IDLE, LOAD, DIV, DONE; IDLE->LOAD on in_valid&&in_ready; LOAD->DIV if d!=0, else LOAD->DONE; DIV->DONE after N iterations; DONE->IDLE on out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE; operands are captured on the accepting edge and input changes afterward have no effect.
REQ-018 out_valid SHALL be 1 only in DONE; out_real, out_imag, div_zero and sat hold stable while out_valid=1 and out_ready=0.
REQ-019 Latency: out_valid rises N+2 cycles after the accepting edge (27 at defaults); divide-by-zero path rises 2 cycles after it.
REQ-020 Divide by zero SHALL give out_real=out_imag=0, div_zero=1, sat=0.
REQ-021 A quotient outside [-2^(data_out_w-1), 2^(data_out_w-1)-1] SHALL clamp to the nearest bound and set sat=1.
REQ-022 The two components SHALL divide in parallel, sharing d and the iteration counter.
REQ-023 Back-to-back: a new operand can be accepted the cycle after the DONE->IDLE transition; there is no overlap.

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE, in_ready=0 during reset, out_valid=0, out_real=out_imag=0, div_zero=0, sat=0, and clear the counter.
REQ-025 Reset mid-DIV or mid-DONE SHALL abort the operation; no result is presented after release.
REQ-026 in_ready SHALL be 1 from the first clock edge after reset_n deasserts.

Structure
REQ-027 Shared package sdft_pkg SHALL hold the FSM state encoding and the width/iteration-count derivation functions; complex_mult also uses those width rules.
REQ-028 A sub-module serial_udiv (unsigned restoring divider, start/busy/done) SHALL be instantiated twice, once for the real component and once for the imaginary component.

Verification
REQ-029 a=(4,0), b=(2,0) -> out=(512,0), div_zero=0, sat=0, out_valid 27 cycles after accept.
REQ-030 a=(1,1), b=(1,-1) -> out=(0,256); a=(0,3), b=(0,3) -> out=(256,0).
REQ-031 a=(-1,0), b=(3,0) -> out_real=-85 (truncation toward zero), out_imag=0; a=(-7,0), b=(2,0) -> out_real=-896.
REQ-032 a=(-128,-128), b=(0,1) -> out=(-32768,32767), sat=1.
REQ-033 b=(0,0), any a -> out=(0,0), div_zero=1, out_valid 2 cycles after accept.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0; pulse reset_n low mid-DIV -> out_valid never rises and in_ready=1 after release.
